div: RTL and testbench

- Multi-cycle 32-bit integer divider that sits beside the EX stage and serves DIV and DIVU.
- EX raises start_i with both operands and holds the request until ready_o. EX stalls the pipeline in the meantime.
- On completion the block returns the 64-bit result {remainder, quotient}, which EX writes to HI/LO.
- Uses radix-2 restoring division with sign fix-up: one quotient bit per clock.

---
 rtl/div.sv | 150 +++++++++++++++
 tb/tb_div.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/div.sv
// ----------------------------------------------------------------------------
// div : multi-cycle 32-bit integer divider for DIV / DIVU.
//
// Radix-2 restoring division producing one quotient bit per clock, followed
// by a single sign fix-up cycle. Division by zero short-circuits to a zero
// result after one cycle.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       cancel an in-flight divide
//   result_o      {remainder, quotient}
//   ready_o       result valid
// ----------------------------------------------------------------------------
module div #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] ONE   = 1;
    localparam logic [5:0]        LAST  = 6'(DATA_W);

    state_e                  state_q;
    logic [5:0]              cnt_q;
    logic [2*DATA_W:0]       dividend_q;
    logic [DATA_W-1:0]       divisor_q;
    logic                    signed_q;
    logic                    op1_sign_q;
    logic                    op2_sign_q;
    logic [2*DATA_W-1:0]     result_q;
    logic                    ready_q;

    // Two's-complement negation, used both for operand magnitude and fix-up.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + ONE;
    endfunction

    // Operand magnitudes as seen on the request cycle.
    logic [DATA_W-1:0] op1_abs_d;
    logic [DATA_W-1:0] op2_abs_d;
    assign op1_abs_d = (signed_div_i && opdata1_i[DATA_W-1]) ? negate(opdata1_i) : opdata1_i;
    assign op2_abs_d = (signed_div_i && opdata2_i[DATA_W-1]) ? negate(opdata2_i) : opdata2_i;

    // Trial subtraction of the divisor from the current partial remainder;
    // bit DATA_W is the borrow and decides whether to restore.
    logic [DATA_W:0] diff_d;
    assign diff_d = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

    // Sign fix-up: quotient negative when operand signs differ, remainder
    // follows the dividend's sign (truncation toward zero).
    logic [DATA_W-1:0] quot_d;
    logic [DATA_W-1:0] rem_d;
    assign quot_d = (signed_q && (op1_sign_q != op2_sign_q))
                    ? negate(dividend_q[DATA_W-1:0]) : dividend_q[DATA_W-1:0];
    assign rem_d  = (signed_q && op1_sign_q)
                    ? negate(dividend_q[2*DATA_W:DATA_W+1]) : dividend_q[2*DATA_W:DATA_W+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            op1_sign_q <= 1'b0;
            op2_sign_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q    <= S_ON;
                            signed_q   <= signed_div_i;
                            op1_sign_q <= opdata1_i[DATA_W-1];
                            op2_sign_q <= opdata2_i[DATA_W-1];
                            dividend_q <= {{DATA_W{1'b0}}, op1_abs_d, 1'b0};
                            divisor_q  <= op2_abs_d;
                            cnt_q      <= '0;
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state_q <= S_FREE;
                    end else begin
                        dividend_q <= '0;
                        result_q   <= '0;
                        ready_q    <= 1'b1;
                        state_q    <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q <= S_FREE;
                        ready_q <= 1'b0;
                    end else if (cnt_q != LAST) begin
                        if (diff_d[DATA_W]) begin
                            dividend_q <= {dividend_q[2*DATA_W-1:0], 1'b0};
                        end else begin
                            dividend_q <= {diff_d[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
                        end
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        result_q <= {rem_d, quot_d};
                        ready_q  <= 1'b1;
                        state_q  <= S_END;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        state_q  <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: state_q <= S_FREE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk;
    logic        rst;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int total = 0;
    int bad   = 0;

    div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sd),
        .opdata1_i    (a),
        .opdata2_i    (b),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    // Called just after a clock edge; the next edge is the accepting edge E0.
    task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y);
        sd    = s;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Counts edges after E0 until ready_o is seen (bounded).
    task automatic wait_ready(input string tag, input int exp_lat);
        int  n;
        bit  got;
        n   = 99;
        got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                n   = i;
                got = 1;
            end
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    endtask

    // Full transaction with handshake hold and release.
    task automatic run_div(input string tag, input logic s, input logic [31:0] x,
                           input logic [31:0] y, input int lat, input logic [63:0] exp_r);
        start_op(s, x, y);
        wait_ready(tag, lat);
        chk({tag, "_res"}, result, exp_r);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_rdy"}, 64'(ready), 64'd1);
            chk({tag, "_hold_res"}, result, exp_r);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        chk({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b0; start = 1'b0; annul = 1'b0; sd = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_div("u7_2",   1'b0, 32'd7,        32'd2,        33, 64'h00000001_00000003);
        run_div("sm7_2",  1'b1, 32'hFFFFFFF9, 32'd2,        33, 64'hFFFFFFFF_FFFFFFFD);
        run_div("s7_m2",  1'b1, 32'd7,        32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
        run_div("sm7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 64'hFFFFFFFF_00000003);
        run_div("uF9_2",  1'b0, 32'hFFFFFFF9, 32'd2,        33, 64'h00000001_7FFFFFFC);
        run_div("u100_7", 1'b0, 32'd100,      32'd7,        33, 64'h00000002_0000000E);
        run_div("u_by0",  1'b0, 32'd100,      32'd0,        1,  64'd0);
        run_div("s_by0",  1'b1, 32'd100,      32'd0,        1,  64'd0);

        // Annul at E10: divide is dropped and never completes.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul_rdy", 64'(ready), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) seen = 1;
        end
        chk("annul_never_rdy", 64'(seen), 64'd0);
        run_div("uFF_1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, 64'h00000000_FFFFFFFF);

        // Asynchronous reset mid-divide (after E15).
        start_op(1'b0, 32'd7, 32'd2);
        repeat (15) @(posedge clk);
        #1;
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_mid_rdy", 64'(ready), 64'd0);
        chk("arst_mid_res", result, 64'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while a result is being presented.
        start_op(1'b0, 32'd7, 32'd2);
        wait_ready("arst_end", 33);
        chk("arst_end_pre", result, 64'h00000001_00000003);
        #2 rst = 1'b0;
        #1;
        chk("arst_end_rdy", 64'(ready), 64'd0);
        chk("arst_end_res", result, 64'd0);
        start = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // No overflow trap on the most negative value divided by -1.
        run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
